// File: rtl/cache_miss_controller.sv
// Data-cache miss sequencer: write-back / write-allocate with
// configurable memory latency, block size and a saturating miss counter.
module cache_miss_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 1,
    parameter int CNT_WIDTH   = 16,
    localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 cache_hit,
    input  logic                 cache_dirty,
    output logic                 pc_enable,
    output logic                 busy,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 mem_addr_sel,
    output logic [WW-1:0]        word_idx,
    output logic                 we_cache,
    output logic                 cache_input_type,
    output logic                 set_valid,
    output logic                 set_dirty,
    output logic                 mem_reg_write,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        DONE
    } state_t;

    state_t               state, state_n;
    logic [LW-1:0]        lat_cnt, lat_n;
    logic [WW-1:0]        word_q, word_n;
    logic                 op_load, op_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 last_lat, last_word, any_op;

    assign last_lat  = (lat_cnt == LW'(MEM_LATENCY - 1));
    assign last_word = (word_q == WW'(BLOCK_WORDS - 1));
    assign any_op    = is_load | is_store;

    // State, counters and op latch; synchronous reset clears all of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            word_q     <= '0;
            op_load    <= 1'b0;
            miss_count <= '0;
        end else begin
            state      <= state_n;
            lat_cnt    <= lat_n;
            word_q     <= word_n;
            op_load    <= op_n;
            miss_count <= cnt_n;
        end
    end

    // Next-state, counter updates and strobes; all strobes held low in reset.
    always_comb begin
        state_n          = state;
        lat_n            = lat_cnt;
        word_n           = word_q;
        op_n             = op_load;
        cnt_n            = miss_count;
        pc_enable        = 1'b0;
        busy             = 1'b0;
        mem_we           = 1'b0;
        mem_re           = 1'b0;
        mem_addr_sel     = 1'b0;
        word_idx         = '0;
        we_cache         = 1'b0;
        cache_input_type = 1'b0;
        set_valid        = 1'b0;
        set_dirty        = 1'b0;
        mem_reg_write    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!any_op) begin
                    pc_enable = 1'b1;
                end else if (cache_hit) begin
                    pc_enable = 1'b1;
                    if (is_load) begin
                        mem_reg_write = 1'b1;
                    end else begin
                        we_cache         = 1'b1;
                        cache_input_type = 1'b1;
                        set_valid        = 1'b1;
                        set_dirty        = 1'b1;
                    end
                end else begin
                    op_n   = is_load;
                    lat_n  = '0;
                    word_n = '0;
                    if (miss_count != {CNT_WIDTH{1'b1}}) begin
                        cnt_n = miss_count + CNT_WIDTH'(1);
                    end
                    state_n = cache_dirty ? WB : REFILL;
                end
            end
            WB: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                word_idx = word_q;
                if (last_lat) begin
                    lat_n = '0;
                    if (last_word) begin
                        word_n  = '0;
                        state_n = REFILL;
                    end else begin
                        word_n = word_q + WW'(1);
                    end
                end else begin
                    lat_n = lat_cnt + LW'(1);
                end
            end
            REFILL: begin
                busy         = 1'b1;
                mem_re       = 1'b1;
                mem_addr_sel = 1'b1;
                word_idx     = word_q;
                if (last_lat) begin
                    we_cache  = 1'b1;
                    set_valid = 1'b1;
                    lat_n     = '0;
                    if (last_word) begin
                        word_n  = '0;
                        state_n = DONE;
                    end else begin
                        word_n = word_q + WW'(1);
                    end
                end else begin
                    lat_n = lat_cnt + LW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                pc_enable = 1'b1;
                if (op_load) begin
                    mem_reg_write = 1'b1;
                end else begin
                    we_cache         = 1'b1;
                    cache_input_type = 1'b1;
                    set_valid        = 1'b1;
                    set_dirty        = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (!rst_n) begin
            pc_enable        = 1'b0;
            busy             = 1'b0;
            mem_we           = 1'b0;
            mem_re           = 1'b0;
            mem_addr_sel     = 1'b0;
            word_idx         = '0;
            we_cache         = 1'b0;
            cache_input_type = 1'b0;
            set_valid        = 1'b0;
            set_dirty        = 1'b0;
            mem_reg_write    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: three parameterisations driven in
// parallel, checked each cycle against a transaction-level model.
module tb_cache_miss_controller;

    typedef struct packed {
        logic        pc;
        logic        busy;
        logic        we;
        logic        re;
        logic        sel;
        logic [7:0]  wi;
        logic        wc;
        logic        cit;
        logic        sv;
        logic        sd;
        logic        mrw;
        logic [15:0] mc;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic is_load = 1'b0;
    logic is_store = 1'b0;
    logic cache_hit = 1'b0;
    logic cache_dirty = 1'b0;

    logic pc [3];
    logic bz [3];
    logic mw [3];
    logic mr [3];
    logic ms [3];
    logic wc [3];
    logic ct [3];
    logic sv [3];
    logic sd [3];
    logic mrw [3];
    logic [0:0]  wi0;
    logic [1:0]  wi1;
    logic [0:0]  wi2;
    logic [15:0] mc0;
    logic [15:0] mc1;
    logic [1:0]  mc2;
    outs_t o [3];

    int L [3] = '{4, 2, 1};
    int N [3] = '{1, 4, 2};
    int CMAX [3] = '{65535, 65535, 3};

    int k [3] = '{-1, -1, -1};
    int cnt [3] = '{0, 0, 0};
    int ld [3] = '{0, 0, 0};
    int dt [3] = '{0, 0, 0};

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    int stall [3];
    int re_n [3];
    int rw [3];
    int wbq [$];

    always #5 clk = ~clk;

    cache_miss_controller #(.MEM_LATENCY(4), .BLOCK_WORDS(1), .CNT_WIDTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .pc_enable(pc[0]), .busy(bz[0]), .mem_we(mw[0]), .mem_re(mr[0]),
        .mem_addr_sel(ms[0]), .word_idx(wi0), .we_cache(wc[0]),
        .cache_input_type(ct[0]), .set_valid(sv[0]), .set_dirty(sd[0]),
        .mem_reg_write(mrw[0]), .miss_count(mc0));

    cache_miss_controller #(.MEM_LATENCY(2), .BLOCK_WORDS(4), .CNT_WIDTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .pc_enable(pc[1]), .busy(bz[1]), .mem_we(mw[1]), .mem_re(mr[1]),
        .mem_addr_sel(ms[1]), .word_idx(wi1), .we_cache(wc[1]),
        .cache_input_type(ct[1]), .set_valid(sv[1]), .set_dirty(sd[1]),
        .mem_reg_write(mrw[1]), .miss_count(mc1));

    cache_miss_controller #(.MEM_LATENCY(1), .BLOCK_WORDS(2), .CNT_WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .pc_enable(pc[2]), .busy(bz[2]), .mem_we(mw[2]), .mem_re(mr[2]),
        .mem_addr_sel(ms[2]), .word_idx(wi2), .we_cache(wc[2]),
        .cache_input_type(ct[2]), .set_valid(sv[2]), .set_dirty(sd[2]),
        .mem_reg_write(mrw[2]), .miss_count(mc2));

    assign o[0] = {pc[0], bz[0], mw[0], mr[0], ms[0], 8'(wi0),
                   wc[0], ct[0], sv[0], sd[0], mrw[0], 16'(mc0)};
    assign o[1] = {pc[1], bz[1], mw[1], mr[1], ms[1], 8'(wi1),
                   wc[1], ct[1], sv[1], sd[1], mrw[1], 16'(mc1)};
    assign o[2] = {pc[2], bz[2], mw[2], mr[2], ms[2], 8'(wi2),
                   wc[2], ct[2], sv[2], sd[2], mrw[2], 16'(mc2)};

    // Model: k=-1 idle; k=1..T memory transfer cycles; k=T+1 completion.
    function automatic int xfer(int i);
        return N[i] * L[i] * (dt[i] != 0 ? 2 : 1);
    endfunction

    function automatic outs_t expect_out(int i);
        outs_t e;
        int j;
        int r;
        int nl;
        e = '0;
        e.mc = 16'(cnt[i]);
        if (!rst_n) return e;
        nl = N[i] * L[i];
        if (k[i] < 0) begin
            if (!(is_load || is_store)) begin
                e.pc = 1'b1;
            end else if (cache_hit) begin
                e.pc = 1'b1;
                if (is_load) e.mrw = 1'b1;
                else {e.wc, e.cit, e.sv, e.sd} = 4'hf;
            end
        end else if (k[i] <= xfer(i)) begin
            e.busy = 1'b1;
            j = k[i] - 1;
            if (dt[i] != 0 && j < nl) begin
                e.we = 1'b1;
                e.wi = 8'(j / L[i]);
            end else begin
                r = j - ((dt[i] != 0) ? nl : 0);
                e.re = 1'b1;
                e.sel = 1'b1;
                e.wi = 8'(r / L[i]);
                if (r % L[i] == L[i] - 1) begin
                    e.wc = 1'b1;
                    e.sv = 1'b1;
                end
            end
        end else begin
            e.busy = 1'b1;
            e.pc = 1'b1;
            if (ld[i] != 0) e.mrw = 1'b1;
            else {e.wc, e.cit, e.sv, e.sd} = 4'hf;
        end
        return e;
    endfunction

    // Advance the model at each clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                k[i] = -1;
                cnt[i] = 0;
                ld[i] = 0;
                dt[i] = 0;
            end else if (k[i] < 0) begin
                if ((is_load || is_store) && !cache_hit) begin
                    k[i] = 1;
                    ld[i] = is_load ? 1 : 0;
                    dt[i] = cache_dirty ? 1 : 0;
                    if (cnt[i] < CMAX[i]) cnt[i] = cnt[i] + 1;
                end
            end else if (k[i] == xfer(i) + 1) begin
                k[i] = -1;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 3; i++) begin
                outs_t e;
                e = expect_out(i);
                checks++;
                if (o[i] !== e) begin
                    failures++;
                    $display("FAIL cycle_outputs inst%0d t=%0t got=%h exp=%h",
                             i, $time, o[i], e);
                end
            end
        end
    end

    // Tallies used by the literal checks.
    always @(negedge clk) begin
        if (run && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (!pc[i]) stall[i]++;
                if (mr[i]) re_n[i]++;
                if (mr[i] && wc[i]) rw[i]++;
            end
            if (mw[1]) wbq.push_back(int'(wi1));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 3; i++) begin
            stall[i] = 0;
            re_n[i] = 0;
            rw[i] = 0;
        end
        wbq.delete();
    endtask

    task automatic op(input bit l, input bit s, input bit h,
                      input bit d, input bit tog);
        clear_tally();
        is_load = l;
        is_store = s;
        cache_hit = h;
        cache_dirty = d;
        @(posedge clk);
        #1;
        is_load = 1'b0;
        is_store = 1'b0;
        cache_hit = tog;
        cache_dirty = tog;
        repeat (20) @(posedge clk);
        #1;
        cache_hit = 1'b0;
        cache_dirty = 1'b0;
    endtask

    int mexp [5] = '{1, 2, 3, 3, 3};
    int wexp [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin
        @(posedge clk);
        #1;
        run = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        is_load = 1'b1;
        cache_hit = 1'b1;
        @(negedge clk);
        chk("hit_load_pc", int'(pc[0]), 1);
        chk("hit_load_mrw", int'(mrw[0]), 1);
        chk("hit_load_busy", int'(bz[0]), 0);
        chk("reset_miss_count", int'(mc0), 0);
        @(posedge clk);
        #1;
        is_load = 1'b0;
        cache_hit = 1'b0;

        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clean_stall_l4n1", stall[0], 5);
        chk("clean_re_l4n1", re_n[0], 4);
        chk("clean_fill_l4n1", rw[0], 1);
        chk("clean_count_l4n1", int'(mc0), 1);
        chk("clean_stall_l1n2", stall[2], 3);

        op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("dirty_stall_l2n4", stall[1], 17);
        chk("dirty_re_l2n4", re_n[1], 8);
        chk("dirty_fill_l2n4", rw[1], 4);
        chk("dirty_wb_len", wbq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("dirty_wb_word", (i < wbq.size()) ? wbq[i] : -1, wexp[i]);
        end
        chk("dirty_stall_l4n1", stall[0], 9);

        op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("store_hit_stall", stall[0], 0);

        is_load = 1'b1;
        cache_dirty = 1'b1;
        @(posedge clk);
        #1;
        is_load = 1'b0;
        cache_dirty = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_abort_we", int'(mw[0]), 0);
        chk("rst_abort_re", int'(mr[0]), 0);
        chk("rst_abort_busy", int'(bz[0]), 0);
        chk("rst_abort_cnt", int'(mc0), 0);
        @(posedge clk);
        #1;
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_hit_stall", stall[0], 0);

        for (int m = 0; m < 5; m++) begin
            op(1'b1, 1'b0, 1'b0, 1'b0, m == 1);
            chk("sat_count", int'(mc2), mexp[m]);
            if (m == 1) begin
                chk("toggle_stall_l1n2", stall[2], 3);
                chk("toggle_stall_l4n1", stall[0], 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
